// File: rtl/keypad_scan_pkg.sv
// ============================================================================
// Module      : keypad_scan_pkg
// Description : Shared types and decode constants for the 4x4 keypad scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_scan_pkg;

    localparam int KEY_W      = 4;
    localparam int FIFO_DEPTH = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_DEBOUNCE = 2'd1;
    localparam state_t ST_PRESSED  = 2'd2;
    localparam state_t ST_RELEASE  = 2'd3;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } result_t;

    // Column drive and row sense share the same MSB-first one-hot encoding
    localparam logic [3:0] C_IDX0 = 4'b1000;
    localparam logic [3:0] C_IDX1 = 4'b0100;
    localparam logic [3:0] C_IDX2 = 4'b0010;
    localparam logic [3:0] C_IDX3 = 4'b0001;

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        case (v)
            C_IDX0:  return 2'd0;
            C_IDX1:  return 2'd1;
            C_IDX2:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_key_fifo.sv
// ============================================================================
// Module      : keypad_key_fifo
// Description : Key output buffer; single holding register when DEPTH==1,
//               circular FIFO otherwise. Drops pushes when full, pulses overrun.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_key_fifo
    import keypad_scan_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [KEY_W-1:0] i_data,
    input  logic             i_ready,
    output logic [KEY_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    generate
        if (DEPTH == 1) begin : g_reg
            logic [KEY_W-1:0] r_data;
            logic             r_valid;
            logic             r_ovr;
            logic             w_pop;

            assign w_pop = r_valid & i_ready;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                    r_ovr   <= 1'b0;
                end else begin
                    r_ovr <= i_push & r_valid & ~w_pop;
                    if (i_push && (!r_valid || w_pop)) begin
                        r_data  <= i_data;
                        r_valid <= 1'b1;
                    end else if (w_pop) begin
                        r_valid <= 1'b0;
                    end
                end
            end

            assign o_data    = r_data;
            assign o_valid   = r_valid;
            assign o_overrun = r_ovr;
        end else begin : g_fifo
            localparam int PW = $clog2(DEPTH);
            localparam int CW = $clog2(DEPTH + 1);

            logic [KEY_W-1:0] r_mem [DEPTH];
            logic [PW-1:0]    r_rd;
            logic [PW-1:0]    r_wr;
            logic [CW-1:0]    r_count;
            logic [KEY_W-1:0] r_last;
            logic             r_ovr;
            logic             w_full;
            logic             w_pop;
            logic             w_wr_en;

            assign w_full  = (r_count == CW'(DEPTH));
            assign w_pop   = (r_count != '0) & i_ready;
            assign w_wr_en = i_push & (~w_full | w_pop);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
                    r_rd    <= '0;
                    r_wr    <= '0;
                    r_count <= '0;
                    r_last  <= '0;
                    r_ovr   <= 1'b0;
                end else begin
                    r_ovr <= i_push & w_full & ~w_pop;
                    if (w_wr_en) begin
                        r_mem[r_wr] <= i_data;
                        r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
                    end
                    if (w_pop) begin
                        r_last <= r_mem[r_rd];
                        r_rd   <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
                    end
                    case ({w_wr_en, w_pop})
                        2'b10:   r_count <= r_count + CW'(1);
                        2'b01:   r_count <= r_count - CW'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end

            // Empty buffer presents the most recently consumed key
            assign o_data    = (r_count != '0) ? r_mem[r_rd] : r_last;
            assign o_valid   = (r_count != '0);
            assign o_overrun = r_ovr;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
// Module      : keypad_scan
// Description : 4x4 keypad scan-round evaluator with press/release debounce.
//               Define KEYPAD_SCAN_FIFO_EN for a 4-deep key FIFO, otherwise a
//               single holding register buffers the output key.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       signal,
    input  logic [3:0]       row,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             overrun
);

`ifdef KEYPAD_SCAN_FIFO_EN
    localparam int c_BUF_DEPTH = FIFO_DEPTH;
`else
    localparam int c_BUF_DEPTH = 1;
`endif
    localparam logic [2:0] c_DEB = 3'(DEBOUNCE_SCANS);

    logic             r_acc_hit;
    logic             r_acc_multi;
    logic [KEY_W-1:0] r_acc_code;
    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [KEY_W-1:0] r_cand;

    logic             w_sig_valid;
    logic             w_hit;
    logic             w_eval;
    logic             w_hit_n;
    logic             w_multi_n;
    logic [KEY_W-1:0] w_code;
    logic [KEY_W-1:0] w_code_n;
    result_t          w_result;
    logic [2:0]       w_cnt_inc;
    state_t           w_state_n;
    logic [2:0]       w_cnt_n;
    logic [KEY_W-1:0] w_cand_n;
    logic             w_push;
    logic [KEY_W-1:0] w_push_code;

    assign w_sig_valid = $onehot(signal);
    assign w_hit       = w_sig_valid & (row != 4'b0000);
    assign w_eval      = w_sig_valid & (signal == C_IDX3);
    assign w_code      = {onehot_idx(row), onehot_idx(signal)};

    // Round summary including the current sample, so col3 is evaluated in-edge
    assign w_hit_n   = r_acc_hit | w_hit;
    assign w_multi_n = r_acc_multi | (w_hit & (~$onehot(row) | r_acc_hit));
    assign w_code_n  = (w_hit && !r_acc_hit) ? w_code : r_acc_code;
    assign w_result  = !w_hit_n ? RES_NONE : (w_multi_n ? RES_MULTI : RES_SINGLE);
    assign w_cnt_inc = r_cnt + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_hit   <= 1'b0;
            r_acc_multi <= 1'b0;
            r_acc_code  <= '0;
        end else if (w_eval) begin
            r_acc_hit   <= 1'b0;
            r_acc_multi <= 1'b0;
            r_acc_code  <= '0;
        end else if (w_sig_valid) begin
            r_acc_hit   <= w_hit_n;
            r_acc_multi <= w_multi_n;
            r_acc_code  <= w_code_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_cand_n    = r_cand;
        w_push      = 1'b0;
        w_push_code = w_code_n;
        if (w_eval) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_result == RES_SINGLE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            w_push    = 1'b1;
                            w_state_n = ST_PRESSED;
                        end else begin
                            w_cand_n  = w_code_n;
                            w_cnt_n   = 3'd1;
                            w_state_n = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_result == RES_SINGLE && w_code_n == r_cand) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc == c_DEB) begin
                            w_push      = 1'b1;
                            w_push_code = r_cand;
                            w_state_n   = ST_PRESSED;
                        end
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (w_result == RES_NONE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            w_state_n = ST_IDLE;
                        end else begin
                            w_cnt_n   = 3'd1;
                            w_state_n = ST_RELEASE;
                        end
                    end
                end
                default: begin
                    if (w_result == RES_NONE) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc == c_DEB) w_state_n = ST_IDLE;
                    end else begin
                        w_state_n = ST_PRESSED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_cand  <= w_cand_n;
        end
    end

    keypad_key_fifo #(
        .DEPTH(c_BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .i_push   (w_push),
        .i_data   (w_push_code),
        .i_ready  (key_ready),
        .o_data   (key_code),
        .o_valid  (key_valid),
        .o_overrun(overrun)
    );

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ============================================================================
// Module      : tb_keypad_scan
// Description : Self-checking bench for keypad_scan with a round/run-based
//               reference model; honours KEYPAD_SCAN_FIFO_EN for buffer depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scan;

    localparam int DS = 3;
`ifdef KEYPAD_SCAN_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] signal;
    logic [3:0] row;
    logic       key_ready;
    logic [3:0] key_code;
    logic       key_valid;
    logic       overrun;

    logic [15:0] press_mask;
    int          row_col;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] q[$];
    logic [3:0] m_last;
    bit         m_ovr;
    int         m_hits, m_code;
    bit         m_pressed;
    int         m_run, m_run_code, m_none_run;

    logic [3:0] pops[$];
    int         ovr_cnt;

    keypad_scan #(.DEBOUNCE_SCANS(DS)) dut (
        .clk      (clk),
        .reset    (reset),
        .signal   (signal),
        .row      (row),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    function automatic int fn_col(input logic [3:0] s);
        case (s)
            4'b1000: return 0;
            4'b0100: return 1;
            4'b0010: return 2;
            4'b0001: return 3;
            default: return -1;
        endcase
    endfunction

    initial begin
        signal = 4'b0000;
        #7 signal = 4'b1000;
        forever begin
            @(posedge clk);
            #2 signal = {signal[0], signal[3:1]};
        end
    end

    // Physical keypad: a held key connects its row to its column while driven
    always_comb begin
        row_col = fn_col(signal);
        row = 4'b0000;
        for (int r = 0; r < 4; r++)
            if (row_col >= 0 && press_mask[r*4 + row_col]) row[3-r] = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic m_clear();
        q.delete();
        m_last = '0; m_ovr = 0; m_hits = 0; m_code = 0;
        m_pressed = 0; m_run = 0; m_run_code = 0; m_none_run = 0;
    endtask

    task automatic m_step();
        bit         pop;
        bit         push;
        logic [3:0] pcode;
        int         c;
        pop = (q.size() > 0) && key_ready;
        push = 0;
        pcode = '0;
        m_ovr = 0;
        c = fn_col(signal);
        if (c >= 0) begin
            for (int r = 0; r < 4; r++)
                if (row[3-r]) begin m_hits++; m_code = r*4 + c; end
            if (c == 3) begin
                if (!m_pressed) begin
                    if (m_hits == 1) begin
                        if (m_run == 0) begin m_run = 1; m_run_code = m_code; end
                        else if (m_code == m_run_code) m_run++;
                        else m_run = 0;
                    end else m_run = 0;
                    if (m_run == DS) begin
                        push = 1; pcode = 4'(m_run_code);
                        m_pressed = 1; m_run = 0; m_none_run = 0;
                    end
                end else begin
                    if (m_hits == 0) m_none_run++; else m_none_run = 0;
                    if (m_none_run == DS) begin m_pressed = 0; m_run = 0; end
                end
                m_hits = 0;
            end
        end
        if (pop) m_last = q.pop_front();
        if (push) begin
            if (q.size() < DEPTH) q.push_back(pcode);
            else m_ovr = 1;
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_clear();
            else m_step();
        end
    end

    initial begin
        ovr_cnt = 0;
        forever begin
            @(negedge clk);
            chk("key_valid", {31'b0, key_valid}, {31'b0, q.size() > 0});
            chk("key_code", {28'b0, key_code}, {28'b0, (q.size() > 0) ? q[0] : m_last});
            chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
            if (key_valid && key_ready) pops.push_back(key_code);
            if (overrun) ovr_cnt++;
        end
    end

    task automatic wait_rounds(input int n);
        repeat (n) begin
            do @(posedge clk); while (signal !== 4'b0001);
            #1;
        end
    endtask

    initial begin
        logic [3:0] exp_drain [4];
        exp_drain[0] = 4'd0; exp_drain[1] = 4'd5; exp_drain[2] = 4'd10; exp_drain[3] = 4'd15;
        key_ready = 1'b1;
        press_mask = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, key_valid}, 32'd0);
        chk("rst_code", {28'b0, key_code}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        wait_rounds(1);
        reset = 1'b1;

        // Clean press of code 6 (row1, col2)
        pops.delete();
        press_mask = 16'(1) << 6;
        wait_rounds(2);
        chk("clean_early", {31'b0, key_valid}, 32'd0);
        wait_rounds(1);
        @(negedge clk);
        chk("clean_rise", {31'b0, key_valid}, 32'd1);
        chk("clean_code", {28'b0, key_code}, 32'd6);
        press_mask = '0;
        wait_rounds(3);
        chk("clean_count", pops.size(), 32'd1);

        // Bounce: 2 hits, 1 empty, 3 hits
        pops.delete();
        press_mask = 16'(1) << 6;
        wait_rounds(2);
        press_mask = '0;
        wait_rounds(1);
        press_mask = 16'(1) << 6;
        wait_rounds(2);
        chk("bounce_early", {31'b0, key_valid}, 32'd0);
        wait_rounds(1);
        @(negedge clk);
        chk("bounce_rise", {31'b0, key_valid}, 32'd1);
        press_mask = '0;
        wait_rounds(3);
        chk("bounce_count", pops.size(), 32'd1);
        chk("bounce_code", (pops.size() > 0) ? {28'b0, pops[0]} : 32'hffff, 32'd6);

        // Ghosting: row0 and row2 in col1
        pops.delete();
        press_mask = (16'(1) << 1) | (16'(1) << 9);
        wait_rounds(5);
        press_mask = '0;
        wait_rounds(3);
        chk("ghost_count", pops.size(), 32'd0);

        // Overrun with consumer stalled
        key_ready = 1'b0;
        pops.delete();
        ovr_cnt = 0;
        foreach (exp_drain[i]) begin
            press_mask = 16'(1) << exp_drain[i];
            wait_rounds(3);
            press_mask = '0;
            wait_rounds(3);
        end
        press_mask = 16'(1) << 3;
        wait_rounds(3);
        press_mask = '0;
        wait_rounds(3);
        chk("ovr_pulses", ovr_cnt, (DEPTH == 4) ? 32'd1 : 32'd4);
        key_ready = 1'b1;
        wait_rounds(2);
        chk("drain_count", pops.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++)
            chk("drain_code", (i < pops.size()) ? {28'b0, pops[i]} : 32'hffff,
                {28'b0, exp_drain[i]});

        // Reset after 2 matching rounds of code 9 (row2, col1)
        pops.delete();
        press_mask = 16'(1) << 9;
        wait_rounds(2);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", {31'b0, key_valid}, 32'd0);
        wait_rounds(1);
        reset = 1'b1;
        wait_rounds(2);
        chk("rstmid_early", {31'b0, key_valid}, 32'd0);
        wait_rounds(1);
        @(negedge clk);
        chk("rstmid_rise", {31'b0, key_valid}, 32'd1);
        chk("rstmid_code", {28'b0, key_code}, 32'd9);
        press_mask = '0;
        wait_rounds(3);
        chk("rstmid_count", pops.size(), 32'd1);

        // Long hold, release, then a second press of the same key
        pops.delete();
        press_mask = 16'(1) << 6;
        wait_rounds(10);
        press_mask = '0;
        wait_rounds(3);
        press_mask = 16'(1) << 6;
        wait_rounds(3);
        press_mask = '0;
        wait_rounds(3);
        chk("hold_count", pops.size(), 32'd2);
        chk("hold_code1", (pops.size() > 1) ? {28'b0, pops[1]} : 32'hffff, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter DEBOUNCE_SCANS, default 3: consecutive identical scan rounds required to accept a press or a release (legal range 1..7).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 signal  input  4  one-hot column drive from the upstream ring-counter stage: 1000=col0, 0100=col1, 0010=col2, 0001=col3.
REQ-005 row  input  4  active-high keypad row sense, already synchronised: row[3]=row0 ... row[0]=row3.
REQ-006 key_code  output  4  key at the head of the output buffer; value = row_index*4 + col_index.
REQ-007 key_valid  output  1  high while the output buffer is non-empty.
REQ-008 key_ready  input  1  consumer accept; a pop occurs on any edge where key_valid and key_ready are both high.
REQ-009 overrun  output  1  one-cycle pulse when an accepted key is dropped because the buffer is full.

Function
REQ-010 Each edge samples signal and row; a sample whose signal is not one-hot is ignored entirely.
REQ-011 A scan round is the set of samples up to and including a sample with signal=0001; the round is evaluated on that edge, and the round accumulator is then cleared.
REQ-012 Round result: NONE if no row bit was set in any sample; SINGLE(code) if exactly one (row, col) hit occurred; MULTI otherwise (two or more rows in one sample, or hits in two or more columns).
REQ-013 FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE; an 3-bit round counter cnt; a 4-bit candidate register cand.
REQ-014 IDLE: on SINGLE(c), set cand=c and cnt=1, then go to DEBOUNCE, or push c directly and go to PRESSED if DEBOUNCE_SCANS=1; on NONE or MULTI, stay in IDLE.
REQ-015 DEBOUNCE: on SINGLE(cand), increment cnt; when cnt reaches DEBOUNCE_SCANS, push cand and go to PRESSED; on any other result, go to IDLE.
REQ-016 PRESSED: on NONE, go to RELEASE with cnt=1, or go to IDLE if DEBOUNCE_SCANS=1; on SINGLE or MULTI, stay in PRESSED (no auto-repeat).
REQ-017 RELEASE: on NONE, increment cnt and go to IDLE when cnt reaches DEBOUNCE_SCANS; on SINGLE or MULTI, return to PRESSED.
REQ-018 A push is written on the round-evaluation edge, so key_valid and key_code are visible in the following cycle.
REQ-019 Push into a full buffer without a simultaneous pop: the new key is dropped, buffer contents are unchanged, and overrun pulses for one cycle.
REQ-020 Simultaneous push and pop when full: both succeed and no overrun is raised; simultaneous push and pop when empty: not possible, since key_valid is low.
REQ-021 key_code holds its last value when empty.

Reset
REQ-022 On reset low: state=IDLE, cnt=0, cand=0, round accumulator cleared, buffer empty, key_code=0, key_valid=0, overrun=0.
REQ-023 Reset mid-debounce or mid-round discards the partial round; after release, the first round starts at the next sample.

Configuration
REQ-024 With KEYPAD_SCAN_FIFO_EN defined, the output buffer is a 4-entry FIFO with wrap-around read and write pointers.
REQ-025 Without KEYPAD_SCAN_FIFO_EN, the buffer is a single holding register: full = key_valid, and REQ-019/REQ-020 apply with depth 1.

Structure
REQ-026 Package keypad_scan_pkg holds the FSM state typedef, KEY_W=4, FIFO_DEPTH=4, and the column/row-index decode constants.
REQ-027 The buffer is a sub-module keypad_key_fifo, parameterised by depth and selected by KEYPAD_SCAN_FIFO_EN; the FSM and round accumulator stay in keypad_scan.

Verification
REQ-028 The bench drives signal from a 4-cycle one-hot ring (1000,0100,0010,0001) released 7 ns after time zero, with a 10 ns clock and DEBOUNCE_SCANS=3.
REQ-029 Clean press: row=0100 asserted only while col2 is driven, for 3 rounds, key_ready=1 -> exactly one key_valid pulse with key_code=6, one cycle after the third col3 edge.
REQ-030 Bounce: row1/col2 hit for 2 rounds, 1 empty round, then 3 hit rounds -> exactly one code 6, accepted after the later 3 rounds only.
REQ-031 Ghosting: row0 and row2 both hit in col1 for 5 rounds -> no key_valid; FSM remains in IDLE.
REQ-032 Overrun: key_ready=0 and 5 distinct debounced presses (codes 0,5,10,15,3) with FIFO enabled -> FIFO holds 0,5,10,15, overrun pulses once (for code 3), and draining yields 0,5,10,15 in order; without the macro -> holds 0, overrun pulses 4 times.
REQ-033 Reset pulse after 2 matching rounds of code 9 -> after release, 3 further rounds are required before 9 is pushed; key_valid=0 throughout reset.
REQ-034 Held key for 10 rounds then release for 3 rounds, followed by a new 3-round press -> one key per press, no repeats.
